// File: rtl/npu_stream_sender_pkg.sv
// Shared widths, FSM encoding and tuser packing for the NPU stream sender.
// tuser field order, MSB first: {row, col, num_channels}.
package npu_stream_sender_pkg;

    localparam int unsigned ADDR_WIDTH         = 13;
    localparam int unsigned DATA_WIDTH         = 8;
    localparam int unsigned MAX_CHANNELS       = 64;
    localparam int unsigned NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1);
    localparam int unsigned CNT_WIDTH          = 2 * ADDR_WIDTH + NUM_CHANNELS_WIDTH;

    typedef enum logic [2:0] {
        SndIdle   = 3'd0,
        SndImg    = 3'd1,
        SndKer    = 3'd2,
        SndFinish = 3'd3
    } snd_state_e;

    function automatic logic [CNT_WIDTH-1:0] pack_tuser(
        input logic [ADDR_WIDTH-1:0]         row,
        input logic [ADDR_WIDTH-1:0]         col,
        input logic [NUM_CHANNELS_WIDTH-1:0] nch
    );
        return {row, col, nch};
    endfunction

    // Full-width product, so the largest tensor never truncates.
    function automatic logic [CNT_WIDTH-1:0] elem_count(
        input logic [ADDR_WIDTH-1:0]         row,
        input logic [ADDR_WIDTH-1:0]         col,
        input logic [NUM_CHANNELS_WIDTH-1:0] nch
    );
        return CNT_WIDTH'(row) * CNT_WIDTH'(col) * CNT_WIDTH'(nch);
    endfunction

endpackage

// File: rtl/npu_stream_sender_if.sv
// AXI-Stream bundle between the host sender (master) and the NPU input (slave).
interface npu_stream_sender_if;
    import npu_stream_sender_pkg::*;

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [CNT_WIDTH-1:0]    tuser;

    modport master (output tdata, tstrb, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO; entry 0 is always the head. Push and pop may coincide,
// including when full.
module axis_skid_fifo2 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                mem_d[count_q[0]] = push_data;
                count_d           = count_q + 2'd1;
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = push_data;
                end else begin
                    mem_d[0] = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    assign count = count_q;
    assign head  = mem_q[0];

endmodule

// File: rtl/npu_stream_sender.sv
// Streams an image tensor then a kernel tensor from a 1-cycle-latency buffer
// as two tlast-terminated AXI-Stream packets carrying shape metadata in tuser.
module npu_stream_sender
    import npu_stream_sender_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         img_row,
    input  logic [ADDR_WIDTH-1:0]         img_col,
    input  logic [ADDR_WIDTH-1:0]         ker_row,
    input  logic [ADDR_WIDTH-1:0]         ker_col,
    input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
    input  logic [ADDR_WIDTH-1:0]         img_base,
    input  logic [ADDR_WIDTH-1:0]         ker_base,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    npu_stream_sender_if.master           m_axis,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    snd_state_e            state_q, state_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CNT_WIDTH-1:0]  img_user_q, img_user_d, ker_user_q, ker_user_d;
    logic [CNT_WIDTH-1:0]  img_len_q, img_len_d, ker_len_q, ker_len_d;
    logic [ADDR_WIDTH-1:0] img_base_q, img_base_d, ker_base_q, ker_base_d;
    logic [CNT_WIDTH-1:0]  rd_idx_q, rd_idx_d;
    logic                  rd_ker_q, rd_ker_d, rd_done_q, rd_done_d;
    logic                  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;

    logic                  dims_ok, accept, issue, rd_is_last, tvalid, tlast, hs;
    logic                  fifo_push, fifo_pop;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH:0]   fifo_head, out_beat;
    logic [CNT_WIDTH-1:0]  cur_len;

    axis_skid_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data({rd_data, rd_last_q}),
        .pop      (fifo_pop),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    // Datapath: read issue, FIFO bypass and stream outputs.
    always_comb begin
        dims_ok = (|img_row) && (|img_col) && (|ker_row) && (|ker_col) && (|num_channels);
        accept  = (state_q == SndIdle) && start && dims_ok;
        cur_len = rd_ker_q ? ker_len_q : img_len_q;
        rd_is_last = (rd_idx_q == cur_len - CNT_WIDTH'(1));
        // Occupancy plus the in-flight read never exceeds the FIFO depth.
        issue   = ((state_q == SndImg) || (state_q == SndKer)) && !rd_done_q &&
                  (({1'b0, fifo_count} + {2'b00, rd_vld_q}) < 3'd2);
        rd_en   = issue;
        rd_addr = issue ? (rd_ker_q ? ker_base_q : img_base_q) + rd_idx_q[ADDR_WIDTH-1:0] : '0;

        tvalid   = (fifo_count != 2'd0) || rd_vld_q;
        out_beat = (fifo_count != 2'd0) ? fifo_head :
                   (rd_vld_q ? {rd_data, rd_last_q} : '0);
        tlast    = out_beat[0];
        hs       = tvalid && m_axis.tready;
        // A fresh read bypasses the FIFO when it can leave immediately.
        fifo_push = rd_vld_q && !((fifo_count == 2'd0) && m_axis.tready);
        fifo_pop  = hs && (fifo_count != 2'd0);

        m_axis.tvalid = tvalid;
        m_axis.tdata  = out_beat[DATA_WIDTH:1];
        m_axis.tlast  = tlast;
        m_axis.tstrb  = {(DATA_WIDTH/8){tvalid}};
        m_axis.tuser  = (state_q == SndImg) ? img_user_q :
                        (state_q == SndKer) ? ker_user_q : '0;
    end

    // Control: FSM, latched configuration and read counters.
    always_comb begin
        state_d    = state_q;
        err_d      = 1'b0;
        img_user_d = img_user_q;
        ker_user_d = ker_user_q;
        img_len_d  = img_len_q;
        ker_len_d  = ker_len_q;
        img_base_d = img_base_q;
        ker_base_d = ker_base_q;
        rd_idx_d   = rd_idx_q;
        rd_ker_d   = rd_ker_q;
        rd_done_d  = rd_done_q;
        rd_vld_d   = issue;
        rd_last_d  = issue && rd_is_last;

        unique case (state_q)
            SndIdle: begin
                if (start && !dims_ok) err_d = 1'b1;
            end
            SndImg:    if (hs && tlast) state_d = SndKer;
            SndKer:    if (hs && tlast) state_d = SndFinish;
            SndFinish: state_d = SndIdle;
            default:   state_d = SndIdle;
        endcase

        if (issue) begin
            if (!rd_is_last) begin
                rd_idx_d = rd_idx_q + CNT_WIDTH'(1);
            end else begin
                rd_idx_d = '0;
                if (rd_ker_q) rd_done_d = 1'b1;
                else          rd_ker_d  = 1'b1;
            end
        end

        if (accept) begin
            state_d    = SndImg;
            img_user_d = pack_tuser(img_row, img_col, num_channels);
            ker_user_d = pack_tuser(ker_row, ker_col, num_channels);
            img_len_d  = elem_count(img_row, img_col, num_channels);
            ker_len_d  = elem_count(ker_row, ker_col, num_channels);
            img_base_d = img_base;
            ker_base_d = ker_base;
            rd_idx_d   = '0;
            rd_ker_d   = 1'b0;
            rd_done_d  = 1'b0;
        end

        busy_d = (state_d != SndIdle);
        done_d = (state_d == SndFinish);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SndIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            img_user_q <= '0;
            ker_user_q <= '0;
            img_len_q  <= '0;
            ker_len_q  <= '0;
            img_base_q <= '0;
            ker_base_q <= '0;
            rd_idx_q   <= '0;
            rd_ker_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            img_user_q <= img_user_d;
            ker_user_q <= ker_user_d;
            img_len_q  <= img_len_d;
            ker_len_q  <= ker_len_d;
            img_base_q <= img_base_d;
            ker_base_q <= ker_base_d;
            rd_idx_q   <= rd_idx_d;
            rd_ker_q   <= rd_ker_d;
            rd_done_q  <= rd_done_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_npu_stream_sender.sv
// Table-driven scoreboard bench for npu_stream_sender: each vector pushes its
// expected beats and read addresses, then the DUT output is popped and compared.
module tb_npu_stream_sender;
    import npu_stream_sender_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          start = 1'b0;
    logic [ADDR_WIDTH-1:0]         img_row = '0, img_col = '0, ker_row = '0, ker_col = '0;
    logic [NUM_CHANNELS_WIDTH-1:0] num_channels = '0;
    logic [ADDR_WIDTH-1:0]         img_base = '0, ker_base = '0;
    logic                          rd_en;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0]         rd_data = '0;
    logic                          busy, done, err;

    npu_stream_sender_if m_axis_if ();

    npu_stream_sender dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .img_row     (img_row),
        .img_col     (img_col),
        .ker_row     (ker_row),
        .ker_col     (ker_col),
        .num_channels(num_channels),
        .img_base    (img_base),
        .ker_base    (ker_base),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .m_axis      (m_axis_if),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0]         ir, ic, kr, kc;
        logic [NUM_CHANNELS_WIDTH-1:0] nch;
        logic [ADDR_WIDTH-1:0]         ib, kb;
        int                            mode;     // 0: tready=1, 1: 1010..., 2: random
        bit                            exp_err;
        bit                            dbl;      // second start while sending image
    } vec_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [CNT_WIDTH-1:0]  user;
    } beat_t;

    beat_t                 exp_q[$];
    logic [ADDR_WIDTH-1:0] addr_q[$];
    logic [ADDR_WIDTH-1:0] addr_exp_q[$];
    int total = 0;
    int bad   = 0;
    vec_t vecs[8];

    function automatic logic [DATA_WIDTH-1:0] mem_byte(input logic [ADDR_WIDTH-1:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    // Buffer model: one-cycle read latency, and a log of every issued address.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_byte(rd_addr);
            addr_q.push_back(rd_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [ADDR_WIDTH-1:0] r, input logic [ADDR_WIDTH-1:0] c,
                            input logic [NUM_CHANNELS_WIDTH-1:0] n,
                            input logic [ADDR_WIDTH-1:0] base);
        int len;
        logic [ADDR_WIDTH-1:0] a;
        beat_t b;
        len = int'(r) * int'(c) * int'(n);
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_WIDTH'(i);
            b.data = mem_byte(a);
            b.last = (i == len - 1);
            b.user = {r, c, n};
            exp_q.push_back(b);
            addr_exp_q.push_back(a);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic run_vec(input vec_t v, input string tag);
        int c, first_v, last_hs, done_c, nbeats;
        bit stalled, seen_done, err_seen;
        beat_t held, cur, e;
        exp_q.delete();
        addr_q.delete();
        addr_exp_q.delete();
        img_row = v.ir; img_col = v.ic; ker_row = v.kr; ker_col = v.kc;
        num_channels = v.nch; img_base = v.ib; ker_base = v.kb;
        if (!v.exp_err) begin
            push_pkt(v.ir, v.ic, v.nch, v.ib);
            push_pkt(v.kr, v.kc, v.nch, v.kb);
        end
        nbeats = exp_q.size();
        m_axis_if.tready = pick_ready(v.mode, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; first_v = -1; last_hs = -1; done_c = -1;
        stalled = 0; seen_done = 0; err_seen = 0; held = '0;
        while (c < 2000 && !seen_done && !(v.exp_err && c >= 8)) begin
            m_axis_if.tready = pick_ready(v.mode, c);
            if (v.dbl && c == 3) begin
                start = 1'b1; img_row = 13'd5;
            end else if (v.dbl && c == 4) begin
                start = 1'b0; img_row = v.ir;
            end
            @(negedge clk);
            if (c == 1) begin
                check({tag, " busy after start"}, busy, !v.exp_err);
                check({tag, " err after start"}, err, v.exp_err);
            end else if (err) begin
                err_seen = 1;
            end
            cur = '{data: m_axis_if.tdata, last: m_axis_if.tlast, user: m_axis_if.tuser};
            if (stalled) begin
                check({tag, " tvalid held"}, m_axis_if.tvalid, 1'b1);
                check({tag, " beat held"}, 64'(cur), 64'(held));
            end
            if (m_axis_if.tvalid && first_v < 0) first_v = c;
            if (m_axis_if.tvalid && m_axis_if.tready) begin
                check({tag, " tstrb"}, m_axis_if.tstrb, 1'b1);
                if (exp_q.size() == 0) begin
                    check({tag, " extra beat"}, 64'(cur), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " beat"}, 64'(cur), 64'(e));
                    if (exp_q.size() == 0) last_hs = c;
                end
            end
            stalled = m_axis_if.tvalid && !m_axis_if.tready;
            held    = cur;
            if (done) begin
                seen_done = 1;
                done_c    = c;
            end
            @(posedge clk); #1;
            c++;
        end
        if (v.exp_err) begin
            check({tag, " tvalid absent"}, first_v, -1);
            check({tag, " done absent"}, seen_done, 1'b0);
            check({tag, " no reads"}, addr_q.size(), 0);
        end else begin
            check({tag, " first tvalid cycle"}, first_v, 2);
            check({tag, " done seen"}, seen_done, 1'b1);
            check({tag, " done after last"}, done_c, last_hs + 1);
            check({tag, " beats left"}, exp_q.size(), 0);
            check({tag, " spurious err"}, err_seen, 1'b0);
            if (v.mode == 0) check({tag, " throughput"}, last_hs, 1 + nbeats);
            check({tag, " read count"}, addr_q.size(), addr_exp_q.size());
            for (int i = 0; i < addr_q.size() && i < addr_exp_q.size(); i++)
                check({tag, " rd_addr"}, addr_q[i], addr_exp_q[i]);
        end
        @(negedge clk);
        check({tag, " busy idle"}, busy, 1'b0);
        check({tag, " done idle"}, done, 1'b0);
        check({tag, " tvalid idle"}, m_axis_if.tvalid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int hs_cnt, cyc;
        vecs[0] = '{ir: 2, ic: 2, kr: 1, kc: 1, nch: 1, ib: 13'h100, kb: 13'h200,
                    mode: 0, exp_err: 0, dbl: 0};
        vecs[1] = '{ir: 3, ic: 3, kr: 2, kc: 1, nch: 2, ib: 13'd10, kb: 13'd500,
                    mode: 1, exp_err: 0, dbl: 0};
        vecs[2] = '{ir: 2, ic: 2, kr: 1, kc: 2, nch: 1, ib: 13'd8190, kb: 13'd8191,
                    mode: 0, exp_err: 0, dbl: 0};
        vecs[3] = '{ir: 2, ic: 2, kr: 1, kc: 0, nch: 1, ib: 13'd0, kb: 13'd0,
                    mode: 0, exp_err: 1, dbl: 0};
        vecs[4] = '{ir: 1, ic: 1, kr: 1, kc: 1, nch: 1, ib: 13'd77, kb: 13'd99,
                    mode: 0, exp_err: 0, dbl: 0};
        vecs[5] = '{ir: 2, ic: 3, kr: 2, kc: 2, nch: 1, ib: 13'd300, kb: 13'd40,
                    mode: 0, exp_err: 0, dbl: 1};
        vecs[6] = '{ir: 4, ic: 2, kr: 3, kc: 3, nch: 3, ib: 13'd1000, kb: 13'd2000,
                    mode: 2, exp_err: 0, dbl: 0};
        vecs[7] = '{ir: 2, ic: 2, kr: 2, kc: 2, nch: 0, ib: 13'd0, kb: 13'd0,
                    mode: 0, exp_err: 1, dbl: 0};

        m_axis_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tvalid", m_axis_if.tvalid, 1'b0);
        check("reset tlast", m_axis_if.tlast, 1'b0);
        check("reset tdata", m_axis_if.tdata, 0);
        check("reset tuser", m_axis_if.tuser, 0);
        check("reset tstrb", m_axis_if.tstrb, 0);
        check("reset rd_en", rd_en, 1'b0);
        check("reset rd_addr", rd_addr, 0);
        check("reset busy/done/err", {busy, done, err}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while image beat 2 of 4 is on the bus.
        img_row = 2; img_col = 2; ker_row = 2; ker_col = 2; num_channels = 1;
        img_base = 13'd50; ker_base = 13'd60;
        m_axis_if.tready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs_cnt = 0;
        cyc = 0;
        while (hs_cnt < 3 && cyc < 50) begin
            @(negedge clk);
            if (m_axis_if.tvalid && m_axis_if.tready) hs_cnt++;
            if (hs_cnt < 3) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        check("reach beat 2", hs_cnt, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid-rst tvalid", m_axis_if.tvalid, 1'b0);
        check("mid-rst busy", busy, 1'b0);
        check("mid-rst rd_en", rd_en, 1'b0);
        check("mid-rst tuser", m_axis_if.tuser, 0);
        @(posedge clk); #1;
        run_vec(vecs[0], "after-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
